// File: rtl/exec_fsm.sv
// Execute-phase Moore controller: latches the instruction word from fetch,
// decodes the opcode and steps the register file, ALU, MAR/MDR, memory and
// PC strobes, then pulses done so that fetch restarts.
//
// The address phase of LOAD/STORE (selected register onto the bus, MARin) is
// performed in DECODE itself. The operand fields are already latched there,
// and doing it in DECODE gives LOAD a 6+k and STORE a 5+k cycle latency.
module exec_fsm #(
    parameter int IR_W        = 16,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ir_valid,
    input  logic [IR_W-1:0] ir,
    input  logic            MFC,
    output logic [1:0]      reg_sel_a,
    output logic [1:0]      reg_sel_b,
    output logic            reg_out_en,
    output logic            reg_wr_en,
    output logic [1:0]      alu_op,
    output logic            alu_out_en,
    output logic            MARin,
    output logic            memEN,
    output logic            RW,
    output logic            MDRreadEN,
    output logic            MDRwriteEN,
    output logic            MDRout,
    output logic            pc_inc,
    output logic            PCin,
    output logic            done,
    output logic            illegal,
    output logic            mem_err
);

    typedef enum logic [3:0] {
        IDLE, DECODE, ALU, WB, LREAD, LLOAD, LWB,
        SDATA, SWRITE, JUMP, PCINC, DONE
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;

    // Last wait cycle on which a missing MFC ends the memory access.
    localparam logic [7:0] WAIT_LAST = 8'(MFC_TIMEOUT - 1);

    state_t          state, state_next;
    logic [IR_W-1:0] ir_q;
    logic [7:0]      wait_cnt;
    logic            set_illegal, set_mem_err;
    logic [3:0]      opcode;
    logic [1:0]      rd, rs;
    logic            mfc_expired;
    logic            unused_ir;

    assign opcode      = ir_q[IR_W-1:IR_W-4];
    assign rd          = ir_q[11:10];
    assign rs          = ir_q[9:8];
    assign mfc_expired = !MFC && (wait_cnt == WAIT_LAST);
    assign unused_ir   = ^ir_q;

    // State, latched instruction, memory wait counter and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ir_q     <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && ir_valid)
                ir_q <= ir;
            if (state != LREAD && state != SWRITE)
                wait_cnt <= '0;
            else if (!MFC)
                wait_cnt <= wait_cnt + 8'd1;
            if (set_illegal)
                illegal <= 1'b1;
            if (set_mem_err)
                mem_err <= 1'b1;
        end
    end

    // Next-state selection, including opcode routing and the MFC timeout.
    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        set_mem_err = 1'b0;
        case (state)
            IDLE:   if (ir_valid) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_NOP:                 state_next = PCINC;
                    OP_ADD, OP_SUB, OP_AND: state_next = ALU;
                    OP_LOAD:                state_next = LREAD;
                    OP_STORE:               state_next = SDATA;
                    OP_JMP:                 state_next = JUMP;
                    default: begin
                        state_next  = PCINC;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ALU:    state_next = WB;
            WB:     state_next = PCINC;
            LREAD: begin
                if (MFC) begin
                    state_next = LLOAD;
                end else if (mfc_expired) begin
                    state_next  = PCINC;
                    set_mem_err = 1'b1;
                end
            end
            LLOAD:  state_next = LWB;
            LWB:    state_next = PCINC;
            SDATA:  state_next = SWRITE;
            SWRITE: begin
                if (MFC) begin
                    state_next = PCINC;
                end else if (mfc_expired) begin
                    state_next  = PCINC;
                    set_mem_err = 1'b1;
                end
            end
            JUMP:   state_next = DONE;
            PCINC:  state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore strobes decoded from the state and the latched instruction.
    always_comb begin
        reg_sel_a  = 2'd0;
        reg_sel_b  = 2'd0;
        reg_out_en = 1'b0;
        reg_wr_en  = 1'b0;
        alu_op     = 2'd0;
        alu_out_en = 1'b0;
        MARin      = 1'b0;
        memEN      = 1'b0;
        RW         = 1'b0;
        MDRreadEN  = 1'b0;
        MDRwriteEN = 1'b0;
        MDRout     = 1'b0;
        pc_inc     = 1'b0;
        PCin       = 1'b0;
        done       = 1'b0;
        case (state)
            DECODE: begin
                if (opcode == OP_LOAD) begin
                    reg_sel_a  = rs;
                    reg_out_en = 1'b1;
                    MARin      = 1'b1;
                end else if (opcode == OP_STORE) begin
                    reg_sel_a  = rd;
                    reg_out_en = 1'b1;
                    MARin      = 1'b1;
                end
            end
            ALU, WB: begin
                reg_sel_a = rd;
                reg_sel_b = rs;
                case (opcode)
                    OP_SUB:  alu_op = 2'b01;
                    OP_AND:  alu_op = 2'b10;
                    default: alu_op = 2'b00;
                endcase
                if (state == WB) begin
                    alu_out_en = 1'b1;
                    reg_wr_en  = 1'b1;
                end
            end
            LREAD: begin
                memEN = 1'b1;
                RW    = 1'b1;
            end
            LLOAD: begin
                memEN     = 1'b1;
                RW        = 1'b1;
                MDRreadEN = 1'b1;
            end
            LWB: begin
                reg_sel_a = rd;
                MDRout    = 1'b1;
                reg_wr_en = 1'b1;
            end
            SDATA: begin
                reg_sel_a  = rs;
                reg_out_en = 1'b1;
                MDRwriteEN = 1'b1;
            end
            SWRITE: memEN = 1'b1;
            JUMP: begin
                reg_sel_a  = rs;
                reg_out_en = 1'b1;
                PCin       = 1'b1;
            end
            PCINC:  pc_inc = 1'b1;
            DONE:   done   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/exec_fsm.md
Name: exec_fsm

Overview:
Moore control FSM for the execute phase of the microcontroller; the stage directly downstream of the instruction-fetch FSM. It captures the instruction word when fetch reports the IR loaded. It decodes the opcode and sequences register-file, ALU, MAR/MDR, memory and PC control strobes on the shared bus. It then pulses done, which restarts instruction fetch.

Parameters:
IR_W, 16, instruction register width (opcode in ir[IR_W-1:IR_W-4])
MFC_TIMEOUT, 15, max cycles waiting for MFC before abort (1..255)

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
ir_valid  in  1  IR loaded by fetch (fetch IRin strobe)
ir  in  IR_W  instruction word; ir[11:10]=rd, ir[9:8]=rs
MFC  in  1  memory function complete
reg_sel_a  out  2  register driven onto bus / ALU A
reg_sel_b  out  2  register for ALU B
reg_out_en  out  1  selected register A drives bus
reg_wr_en  out  1  write bus value to register rd
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 pass-A
alu_out_en  out  1  ALU result drives bus
MARin  out  1  load MAR from bus
memEN  out  1  memory enable
RW  out  1  1=read, 0=write
MDRreadEN  out  1  load MDR from memory
MDRwriteEN  out  1  load MDR from bus
MDRout  out  1  MDR drives bus
pc_inc  out  1  PC += 1
PCin  out  1  load PC from bus
done  out  1  one-cycle instruction-complete pulse to fetch
illegal  out  1  sticky, bad opcode seen
mem_err  out  1  sticky, MFC timeout seen

Behaviour:
- Reset (async): state IDLE, latched IR=0, wait counter=0, all outputs 0 incl. sticky flags. Reset mid-instruction aborts immediately; no done.
- Outputs are a pure function of state and latched IR (Moore). Only one bus driver (reg_out_en/alu_out_en/MDRout) is high per state.
- IDLE: ir_valid=1 latches ir, then DECODE. ir_valid outside IDLE is ignored.
- Opcodes:
  - 0000 NOP
  - 0001 ADD rd=rd+rs
  - 0010 SUB rd=rd-rs
  - 0011 AND rd=rd&rs
  - 0100 LOAD rd=M[rs]
  - 0101 STORE M[rd]=rs
  - 0110 JMP PC=rs
  - 0111-1111 illegal
- DECODE routes:
  - NOP -> PCINC
  - ALU ops -> ALU
  - LOAD -> LADDR
  - STORE -> SADDR
  - JMP -> JUMP
  - illegal -> set illegal, go PCINC
- ALU: reg_sel_a=rd, reg_sel_b=rs, alu_op set. Next WB.
- WB: alu_out_en=1, reg_wr_en=1, alu_op held. Next PCINC.
- LADDR: reg_sel_a=rs, reg_out_en, MARin. Next LREAD.
- LREAD: memEN=1, RW=1. Stays until MFC=1, then LLOAD.
- LLOAD: memEN, RW, MDRreadEN. Next LWB.
- LWB: MDRout, reg_wr_en (rd). Next PCINC.
- SADDR: reg_sel_a=rd, reg_out_en, MARin. Next SDATA.
- SDATA: reg_sel_a=rs, reg_out_en, MDRwriteEN. Next SWRITE.
- SWRITE: memEN=1, RW=0. Stays until MFC=1, then PCINC.
- JUMP: reg_sel_a=rs, reg_out_en, PCin. Next DONE (no increment).
- PCINC: pc_inc=1. Next DONE.
- DONE: done=1. Next IDLE.
- MFC wait (LREAD/SWRITE): counter clears on entry and increments each cycle MFC=0. When the counter reaches MFC_TIMEOUT with MFC still 0: set mem_err, go PCINC. MFC=1 on the timeout cycle counts as success.
- Latency, counted in rising edges from the edge sampling ir_valid to the done-high cycle:
  - NOP: 3
  - ALU: 5
  - JMP: 3
  - LOAD: 6+k (k = extra MFC-wait cycles)
  - STORE: 5+k
- Sticky flags clear only on rst.

Test Plan:
- Reset mid-LREAD (MFC held 0) -> all outputs 0 same cycle, state IDLE; no done pulse.
- ir=0x1600 (ADD r1,r2), ir_valid 1 cycle:
  - WB cycle shows alu_out_en=1, reg_wr_en=1, alu_op=00, reg_sel_a=1, reg_sel_b=2.
  - pc_inc exactly one cycle.
  - done 5 edges after ir_valid.
- ir=0x4900 (LOAD r2,[r1]), MFC high 3 cycles after LREAD entry:
  - MARin with reg_sel_a=1.
  - LREAD lasts 4 cycles.
  - MDRreadEN one cycle, then MDRout+reg_wr_en with reg_sel_a=2.
  - done at edge 9.
- ir=0x5600 (STORE M[r1]=r2), MFC immediately -> MARin (sel 1), then MDRwriteEN (sel 2), then memEN=1/RW=0 one cycle; done at edge 5.
- ir=0x4000, MFC never asserted, MFC_TIMEOUT=15 -> mem_err=1 after 15 wait cycles, pc_inc, done; mem_err remains 1 over the next instruction.
- ir=0x6300 (JMP r3) -> PCin with reg_sel_a=3, pc_inc never asserted, done at edge 3. Then ir=0xF000 -> illegal=1, pc_inc, done at edge 3.
